// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: fetch-side and decode-side handshake bundle for the prefetch queue
interface fetch_buffer_if #(
  parameter int DEPTH = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W = 64
);
  logic                       in_valid;
  logic [INSTR_W-1:0]         in_instruction;
  logic [PC_W-1:0]            in_pc;
  logic                       in_ready;
  logic                       flush;
  logic                       out_valid;
  logic [INSTR_W-1:0]         out_instruction;
  logic [PC_W-1:0]            out_pc;
  logic                       out_ready;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (
    output in_valid, in_instruction, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instruction, out_pc, count
  );
  modport slave (
    input  in_valid, in_instruction, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instruction, out_pc, count
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch queue between fetch and decode with branch flush
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W = 64,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
  input logic           clk,
  input logic           reset,
  fetch_buffer_if.slave fb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic [AW-1:0]      r_rd;
  logic [AW-1:0]      r_wr;
  logic [CW-1:0]      r_count;
  logic               w_push;
  logic               w_pop;
  assign fb.in_ready        = r_count != CW'(DEPTH);
  assign fb.out_valid       = r_count != '0;
  assign fb.count           = r_count;
  assign fb.out_instruction = fb.out_valid ? r_instr[r_rd] : NOP_INSTR;
  assign fb.out_pc          = fb.out_valid ? r_pc[r_rd] : '0;
  assign w_push             = fb.in_valid & fb.in_ready;
  assign w_pop              = fb.out_valid & fb.out_ready;
  // Storage array; contents are don't-care after reset/flush so it needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr] <= fb.in_instruction;
      r_pc[r_wr]    <= fb.in_pc;
    end
  end
  // Pointers and occupancy; reset and flush both discard everything, then push/pop
  always_ff @(posedge clk) begin
    if (reset || fb.flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed vector table plus randomized queue-model check of fetch_buffer
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [63:0] ipc;
    logic        ordy;
    logic        ev;
    logic [63:0] epc;
    logic [2:0]  ecnt;
    logic        erdy;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[$];
  ent_t model[$];

  fetch_buffer_if #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(64)) fb_if ();

  fetch_buffer #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(64), .NOP_INSTR(NOP)) dut (
    .clk  (clk),
    .reset(reset),
    .fb   (fb_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [63:0] pc);
    return 32'h00500093 + {pc[11:0], 20'h0};
  endfunction

  function automatic void add(input logic rst, fl, iv, input logic [63:0] ipc, input logic ordy,
                              input logic ev, input logic [63:0] epc, input logic [2:0] ecnt,
                              input logic erdy);
    vecs.push_back('{rst, fl, iv, ipc, ordy, ev, epc, ecnt, erdy});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input logic rst, fl, iv, input logic [63:0] ipc, input logic [31:0] iinstr,
                     input logic ordy);
    reset = rst;
    fb_if.flush = fl;
    fb_if.in_valid = iv;
    fb_if.in_pc = ipc;
    fb_if.in_instruction = iinstr;
    fb_if.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [63:0] epc,
                          input logic [31:0] einstr, input logic [2:0] ecnt, input logic erdy);
    chk({tag, ".out_valid"}, 64'(fb_if.out_valid), 64'(ev));
    chk({tag, ".out_pc"}, fb_if.out_pc, ev ? epc : 64'h0);
    chk({tag, ".out_instr"}, 64'(fb_if.out_instruction), 64'(ev ? einstr : NOP));
    chk({tag, ".count"}, 64'(fb_if.count), 64'(ecnt));
    chk({tag, ".in_ready"}, 64'(fb_if.in_ready), 64'(erdy));
  endtask

  initial begin
    add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 64'h0, 0, 1, 64'h0, 1, 1);
    add(0, 0, 1, 64'h4, 0, 1, 64'h0, 2, 1);
    add(0, 0, 1, 64'h8, 0, 1, 64'h0, 3, 1);
    add(0, 0, 1, 64'hC, 0, 1, 64'h0, 4, 0);
    add(0, 0, 1, 64'h10, 0, 1, 64'h0, 4, 0);
    add(0, 0, 1, 64'h10, 1, 1, 64'h4, 3, 1);
    add(0, 0, 1, 64'h10, 1, 1, 64'h8, 3, 1);
    add(0, 0, 0, 64'h0, 1, 1, 64'hC, 2, 1);
    add(0, 0, 0, 64'h0, 1, 1, 64'h10, 1, 1);
    add(0, 0, 0, 64'h0, 1, 0, 64'h0, 0, 1);
    for (int i = 0; i < 10; i++) add(0, 0, 1, 64'(i * 4), 1, 1, 64'(i * 4), 1, 1);
    add(0, 0, 0, 64'h0, 1, 0, 64'h0, 0, 1);
    add(0, 0, 1, 64'h200, 0, 1, 64'h200, 1, 1);
    add(0, 0, 1, 64'h204, 0, 1, 64'h200, 2, 1);
    add(0, 0, 1, 64'h208, 0, 1, 64'h200, 3, 1);
    add(0, 1, 1, 64'h40, 1, 0, 64'h0, 0, 1);
    add(0, 0, 1, 64'h100, 0, 1, 64'h100, 1, 1);
    add(0, 0, 1, 64'h104, 0, 1, 64'h100, 2, 1);
    add(1, 1, 1, 64'h300, 1, 0, 64'h0, 0, 1);
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 1);

    foreach (vecs[k]) begin
      cyc(vecs[k].rst, vecs[k].fl, vecs[k].iv, vecs[k].ipc, ins(vecs[k].ipc), vecs[k].ordy);
      chk_outs($sformatf("vec%0d", k), vecs[k].ev, vecs[k].epc, ins(vecs[k].epc),
               vecs[k].ecnt, vecs[k].erdy);
    end

    cyc(1, 0, 0, 0, 0, 0);
    model.delete();
    for (int c = 0; c < 3000; c++) begin
      logic        rst, fl, iv, ordy, rdy;
      logic [63:0] pc;
      logic [31:0] in_i;
      ent_t        head;
      rst  = ($urandom_range(49) == 0);
      fl   = ($urandom_range(19) == 0);
      iv   = ($urandom_range(9) < 7);
      ordy = ($urandom_range(9) < 6);
      pc   = {$urandom, $urandom};
      in_i = $urandom;
      rdy  = model.size() < DEPTH;
      cyc(rst, fl, iv, pc, in_i, ordy);
      if (rst || fl) model.delete();
      else begin
        if (ordy && model.size() > 0) void'(model.pop_front());
        if (iv && rdy) model.push_back('{in_i, pc});
      end
      head = model.size() > 0 ? model[0] : '{NOP, 64'h0};
      chk_outs($sformatf("rnd%0d", c), model.size() > 0, head.pc, head.instr,
               3'(model.size()), model.size() < DEPTH);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
